// File: rtl/core_controller_if.sv
// rtl/core_controller_if.sv - signal bundle between decode/LSU/PC-CSR logic and core_controller (irq_i under CORE_CONTROLLER_IRQ_EN)
interface core_controller_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 4
);
    logic                  inst_valid_i;
    logic                  jump_inst_i;
    logic                  branch_inst_i;
    logic                  ecall_inst_i;
    logic                  ebreak_inst_i;
    logic                  mret_inst_i;
    logic                  illegal_inst_i;
    logic                  lsu_en_i;
    logic                  lsu_done_i;
    logic                  lsu_err_i;
    logic                  md_en_i;
    logic                  md_done_i;
    logic                  comp_result_i;
    logic [ADDR_WIDTH-1:0] mtvec_i;
    logic                  resume_i;
`ifdef CORE_CONTROLLER_IRQ_EN
    logic                  irq_i;
`endif
    logic [CNT_WIDTH-1:0]  cycle_counter_o;
    logic                  deassert_wen_n_o;
    logic                  retire_o;
    logic                  save_epc_o;
    logic                  mret_o;
    logic [ADDR_WIDTH-1:0] exc_pc_o;
    logic                  target_valid_o;
    logic [3:0]            mcause_o;
    logic                  halted_o;

    modport slave (
`ifdef CORE_CONTROLLER_IRQ_EN
        input  irq_i,
`endif
        input  inst_valid_i, jump_inst_i, branch_inst_i, ecall_inst_i, ebreak_inst_i,
               mret_inst_i, illegal_inst_i, lsu_en_i, lsu_done_i, lsu_err_i,
               md_en_i, md_done_i, comp_result_i, mtvec_i, resume_i,
        output cycle_counter_o, deassert_wen_n_o, retire_o, save_epc_o, mret_o,
               exc_pc_o, target_valid_o, mcause_o, halted_o
    );

    modport master (
`ifdef CORE_CONTROLLER_IRQ_EN
        output irq_i,
`endif
        output inst_valid_i, jump_inst_i, branch_inst_i, ecall_inst_i, ebreak_inst_i,
               mret_inst_i, illegal_inst_i, lsu_en_i, lsu_done_i, lsu_err_i,
               md_en_i, md_done_i, comp_result_i, mtvec_i, resume_i,
        input  cycle_counter_o, deassert_wen_n_o, retire_o, save_epc_o, mret_o,
               exc_pc_o, target_valid_o, mcause_o, halted_o
    );
endinterface

// File: rtl/core_controller.sv
// rtl/core_controller.sv - instruction sequencing FSM: redirects, LSU/MD waits, traps, mret, ebreak halt
// Optional interrupt entry from IDLE enabled by CORE_CONTROLLER_IRQ_EN.
module core_controller #(
    parameter int ADDR_WIDTH  = 32,
    parameter int CNT_WIDTH   = 4,
    parameter int LSU_TIMEOUT = 15,
    parameter int VECTORED    = 0
) (
    input logic              clk,
    input logic              rst_n,
    core_controller_if.slave ctrl
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LSU_WAIT = 3'd1;
    localparam logic [2:0] ST_MD_WAIT  = 3'd2;
    localparam logic [2:0] ST_REDIRECT = 3'd3;
    localparam logic [2:0] ST_HALT     = 3'd4;

    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_LSU_FAULT = 4'd5;
    localparam logic [3:0] CAUSE_ECALL     = 4'd11;

    localparam logic [31:0] LSU_TIMEOUT_U = 32'(LSU_TIMEOUT);

    logic [2:0]            state_q, state_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic [3:0]            mcause_q, mcause_d;
    logic                  trap;
    logic [3:0]            trap_cause;
    logic                  lsu_timeout;
    logic [ADDR_WIDTH-1:0] trap_base;

    assign lsu_timeout = (LSU_TIMEOUT != 0) && (32'(cnt_q) == LSU_TIMEOUT_U);
    assign trap_base   = ctrl.mtvec_i & ~ADDR_WIDTH'(3);

    always_comb begin
        state_d               = state_q;
        mcause_d              = mcause_q;
        trap                  = 1'b0;
        trap_cause            = '0;
        ctrl.deassert_wen_n_o = 1'b0;
        ctrl.retire_o         = 1'b0;
        ctrl.save_epc_o       = 1'b0;
        ctrl.mret_o           = 1'b0;
        ctrl.target_valid_o   = 1'b0;
        ctrl.exc_pc_o         = '0;
        ctrl.halted_o         = 1'b0;

        case (state_q)
            ST_HALT: begin
                ctrl.halted_o = 1'b1;
                if (ctrl.resume_i) state_d = ST_IDLE;
            end
            ST_IDLE: if (ctrl.inst_valid_i) begin
                ctrl.deassert_wen_n_o = 1'b1;
                ctrl.retire_o         = 1'b1;
`ifdef CORE_CONTROLLER_IRQ_EN
                if (ctrl.irq_i) begin
                    trap          = 1'b1;
                    trap_cause    = CAUSE_ECALL;
                    ctrl.retire_o = 1'b0;
                end else
`endif
                if (ctrl.illegal_inst_i) begin
                    trap          = 1'b1;
                    trap_cause    = CAUSE_ILLEGAL;
                    ctrl.retire_o = 1'b0;
                end else if (ctrl.ecall_inst_i) begin
                    trap       = 1'b1;
                    trap_cause = CAUSE_ECALL;
                end else if (ctrl.ebreak_inst_i) begin
                    ctrl.deassert_wen_n_o = 1'b0;
                    ctrl.retire_o         = 1'b0;
                    state_d               = ST_HALT;
                end else if (ctrl.mret_inst_i) begin
                    ctrl.mret_o         = 1'b1;
                    ctrl.target_valid_o = 1'b1;
                end else if (ctrl.lsu_en_i) begin
                    ctrl.deassert_wen_n_o = 1'b0;
                    ctrl.retire_o         = 1'b0;
                    state_d               = ST_LSU_WAIT;
                end else if (ctrl.md_en_i) begin
                    ctrl.deassert_wen_n_o = 1'b0;
                    ctrl.retire_o         = 1'b0;
                    state_d               = ST_MD_WAIT;
                end else if (ctrl.jump_inst_i || (ctrl.branch_inst_i && ctrl.comp_result_i)) begin
                    ctrl.retire_o = 1'b0;
                    state_d       = ST_REDIRECT;
                end
            end
            // A bus error beats a simultaneous completion: the load data is not trustworthy.
            ST_LSU_WAIT: if (ctrl.inst_valid_i) begin
                if (ctrl.lsu_err_i || lsu_timeout) begin
                    trap       = 1'b1;
                    trap_cause = CAUSE_LSU_FAULT;
                    state_d    = ST_IDLE;
                end else if (ctrl.lsu_done_i) begin
                    ctrl.deassert_wen_n_o = 1'b1;
                    ctrl.retire_o         = 1'b1;
                    state_d               = ST_IDLE;
                end
            end
            ST_MD_WAIT: if (ctrl.inst_valid_i && ctrl.md_done_i) begin
                ctrl.deassert_wen_n_o = 1'b1;
                ctrl.retire_o         = 1'b1;
                state_d               = ST_IDLE;
            end
            ST_REDIRECT: if (ctrl.inst_valid_i) begin
                ctrl.deassert_wen_n_o = 1'b1;
                ctrl.retire_o         = 1'b1;
                ctrl.target_valid_o   = 1'b1;
                state_d               = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (trap) begin
            ctrl.deassert_wen_n_o = 1'b0;
            ctrl.save_epc_o       = 1'b1;
            ctrl.target_valid_o   = 1'b1;
            ctrl.exc_pc_o         = trap_base +
                ((VECTORED != 0) ? ADDR_WIDTH'({trap_cause, 2'b00}) : '0);
            mcause_d              = trap_cause;
        end
    end

    always_comb begin
        if (state_d == ST_IDLE || state_d != state_q) cnt_d = '0;
        else if (&cnt_q)                              cnt_d = cnt_q;
        else                                          cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            mcause_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcause_q <= mcause_d;
        end
    end

    assign ctrl.cycle_counter_o = cnt_q;
    assign ctrl.mcause_o        = mcause_q;
endmodule

// File: tb/tb_core_controller.sv
// tb/tb_core_controller.sv - self-checking bench for core_controller (VECTORED=1, LSU_TIMEOUT=15)
module tb_core_controller;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    core_controller_if #(.ADDR_WIDTH(32), .CNT_WIDTH(4)) bus ();

    core_controller #(
        .ADDR_WIDTH(32), .CNT_WIDTH(4), .LSU_TIMEOUT(15), .VECTORED(1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .ctrl (bus)
    );

    localparam logic [13:0] FV = 14'h0001, FJ = 14'h0002, FB = 14'h0004, FE = 14'h0008;
    localparam logic [13:0] FEB = 14'h0010, FM = 14'h0020, FI = 14'h0040, FL = 14'h0080;
    localparam logic [13:0] FLD = 14'h0100, FLE = 14'h0200, FMD = 14'h0400, FMDD = 14'h0800;
    localparam logic [13:0] FC = 14'h1000, FR = 14'h2000;

    typedef struct packed {
        logic [13:0] f;
        logic [31:0] mtvec;
    } in_t;

    typedef struct packed {
        logic [3:0]  cnt;
        logic        wen;
        logic        retire;
        logic        save;
        logic        mret;
        logic        tv;
        logic        halted;
        logic [3:0]  mcause;
        logic [31:0] exc;
    } out_t;

    typedef struct {
        in_t  stim;
        out_t exp;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what the core is busy with (0 idle, 1 load/store, 2 mul/div, 3 redirect, 4 halted)
    int         m_kind, nx_kind, m_cycles;
    logic [3:0] m_mcause, nx_mcause;

    task automatic check(input string name, input out_t act, input out_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic out_t sample();
        out_t o;
        o.cnt    = bus.cycle_counter_o;
        o.wen    = bus.deassert_wen_n_o;
        o.retire = bus.retire_o;
        o.save   = bus.save_epc_o;
        o.mret   = bus.mret_o;
        o.tv     = bus.target_valid_o;
        o.halted = bus.halted_o;
        o.mcause = bus.mcause_o;
        o.exc    = bus.exc_pc_o;
        return o;
    endfunction

    function automatic out_t mk_out(logic wen, logic ret, logic save, logic mret, logic tv,
                                    logic [31:0] exc);
        out_t o = '0;
        o.wen = wen; o.retire = ret; o.save = save; o.mret = mret; o.tv = tv; o.exc = exc;
        return o;
    endfunction

    function automatic vec_t mkv(logic [13:0] f, logic [31:0] mt, logic wen, logic ret,
                                 logic save, logic mret, logic tv, logic [31:0] exc);
        vec_t v;
        v.stim = '{f: f, mtvec: mt};
        v.exp  = mk_out(wen, ret, save, mret, tv, exc);
        return v;
    endfunction

    function automatic in_t si(logic [13:0] f, logic [31:0] mt);
        in_t s = '{f: f, mtvec: mt};
        return s;
    endfunction

    task automatic apply(input in_t s);
        bus.inst_valid_i   = |(s.f & FV);
        bus.jump_inst_i    = |(s.f & FJ);
        bus.branch_inst_i  = |(s.f & FB);
        bus.ecall_inst_i   = |(s.f & FE);
        bus.ebreak_inst_i  = |(s.f & FEB);
        bus.mret_inst_i    = |(s.f & FM);
        bus.illegal_inst_i = |(s.f & FI);
        bus.lsu_en_i       = |(s.f & FL);
        bus.lsu_done_i     = |(s.f & FLD);
        bus.lsu_err_i      = |(s.f & FLE);
        bus.md_en_i        = |(s.f & FMD);
        bus.md_done_i      = |(s.f & FMDD);
        bus.comp_result_i  = |(s.f & FC);
        bus.resume_i       = |(s.f & FR);
        bus.mtvec_i        = s.mtvec;
`ifdef CORE_CONTROLLER_IRQ_EN
        bus.irq_i          = 1'b0;
`endif
    endtask

    task automatic step(input in_t s);
        @(negedge clk);
        apply(s);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply('0);
        @(negedge clk);
        rst_n    = 1'b1;
        m_kind   = 0;
        m_cycles = 0;
        m_mcause = '0;
    endtask

    function automatic logic [31:0] trap_pc(logic [31:0] mt, int cause);
        return (mt & ~32'h3) + 32'(cause * 4);
    endfunction

    task automatic model_eval(input in_t s, output out_t o);
        o         = '0;
        o.cnt     = (m_cycles > 15) ? 4'd15 : 4'(m_cycles);
        o.mcause  = m_mcause;
        nx_kind   = m_kind;
        nx_mcause = m_mcause;
        if (m_kind == 4) begin
            o.halted = 1'b1;
            if (|(s.f & FR)) nx_kind = 0;
        end else if (|(s.f & FV)) begin
            case (m_kind)
                0: begin
                    if (|(s.f & FI)) begin
                        o.save = 1; o.tv = 1; o.exc = trap_pc(s.mtvec, 2); nx_mcause = 4'd2;
                    end else if (|(s.f & FE)) begin
                        o.retire = 1; o.save = 1; o.tv = 1; o.exc = trap_pc(s.mtvec, 11);
                        nx_mcause = 4'd11;
                    end else if (|(s.f & FEB)) nx_kind = 4;
                    else if (|(s.f & FM)) begin
                        o.wen = 1; o.retire = 1; o.mret = 1; o.tv = 1;
                    end else if (|(s.f & FL)) nx_kind = 1;
                    else if (|(s.f & FMD)) nx_kind = 2;
                    else if (|(s.f & FJ) || (|(s.f & FB) && |(s.f & FC))) begin
                        o.wen = 1; nx_kind = 3;
                    end else begin
                        o.wen = 1; o.retire = 1;
                    end
                end
                1: begin
                    if (|(s.f & FLE) || o.cnt == 4'd15) begin
                        o.save = 1; o.tv = 1; o.exc = trap_pc(s.mtvec, 5);
                        nx_mcause = 4'd5; nx_kind = 0;
                    end else if (|(s.f & FLD)) begin
                        o.wen = 1; o.retire = 1; nx_kind = 0;
                    end
                end
                2: if (|(s.f & FMDD)) begin
                    o.wen = 1; o.retire = 1; nx_kind = 0;
                end
                default: begin
                    o.wen = 1; o.retire = 1; o.tv = 1; nx_kind = 0;
                end
            endcase
        end
    endtask

    task automatic model_commit();
        if (nx_kind == 0 || nx_kind != m_kind) m_cycles = 0;
        else                                   m_cycles = m_cycles + 1;
        m_kind   = nx_kind;
        m_mcause = nx_mcause;
    endtask

    vec_t vecs[16];

    initial begin
        out_t o, e;
        in_t  s;

        vecs[0]  = mkv(FE | FJ,                 32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mkv(FV,                      32'h0,    1, 1, 0, 0, 0, 32'h0);
        vecs[2]  = mkv(FV | FI,                 32'h100,  0, 0, 1, 0, 1, 32'h108);
        vecs[3]  = mkv(FV | FE,                 32'h103,  0, 1, 1, 0, 1, 32'h12C);
        vecs[4]  = mkv(FV | FEB,                32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[5]  = mkv(FV | FM,                 32'h40,   1, 1, 0, 1, 1, 32'h0);
        vecs[6]  = mkv(FV | FL,                 32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[7]  = mkv(FV | FMD,                32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[8]  = mkv(FV | FJ,                 32'h0,    1, 0, 0, 0, 0, 32'h0);
        vecs[9]  = mkv(FV | FB | FC,            32'h0,    1, 0, 0, 0, 0, 32'h0);
        vecs[10] = mkv(FV | FB,                 32'h0,    1, 1, 0, 0, 0, 32'h0);
        vecs[11] = mkv(FV | FI | FE,            32'h1000, 0, 0, 1, 0, 1, 32'h1008);
        vecs[12] = mkv(FV | FE | FEB | FM,      32'h0,    0, 1, 1, 0, 1, 32'h2C);
        vecs[13] = mkv(FV | FL | FMD | FJ,      32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[14] = mkv(FV | FEB | FM,           32'h0,    0, 0, 0, 0, 0, 32'h0);
        vecs[15] = mkv(FV | FMD | FJ | FB | FC, 32'h0,    0, 0, 0, 0, 0, 32'h0);

        apply('0);
        #1;
        check("reset_async", sample(), '0);
        do_reset();
        #1;
        check("reset_state", sample(), '0);

        foreach (vecs[i]) begin
            do_reset();
            step(vecs[i].stim);
            check($sformatf("vec%0d", i), sample(), vecs[i].exp);
        end

        // ecall with vectored target, mcause updated on the following edge
        do_reset();
        step(si(FV | FE, 32'h100));
        check("ecall_same_cycle", sample(), mk_out(0, 1, 1, 0, 1, 32'h12C));
        step(si(FV, 32'h100));
        e = mk_out(1, 1, 0, 0, 0, 32'h0); e.mcause = 4'd11;
        check("ecall_mcause", sample(), e);

        // LSU completing after three wait cycles
        do_reset();
        step(si(FV | FL, 0));
        check("lsu_issue", sample(), '0);
        for (int k = 0; k < 3; k++) begin
            step(si(FV, 0));
            e = '0; e.cnt = 4'(k);
            check($sformatf("lsu_wait%0d", k), sample(), e);
        end
        step(si(FV | FLD, 0));
        e = mk_out(1, 1, 0, 0, 0, 0); e.cnt = 4'd3;
        check("lsu_done", sample(), e);
        step(si(FV, 0));
        check("lsu_after", sample(), mk_out(1, 1, 0, 0, 0, 0));

        // LSU timeout at counter 15
        do_reset();
        step(si(FV | FL, 32'h200));
        for (int k = 0; k < 15; k++) begin
            step(si(FV, 32'h200));
            e = '0; e.cnt = 4'(k);
            check($sformatf("lsu_to_wait%0d", k), sample(), e);
        end
        step(si(FV, 32'h200));
        e = mk_out(0, 0, 1, 0, 1, 32'h214); e.cnt = 4'd15;
        check("lsu_timeout_trap", sample(), e);
        step(si(FV, 32'h200));
        e = mk_out(1, 1, 0, 0, 0, 0); e.mcause = 4'd5;
        check("lsu_timeout_mcause", sample(), e);

        // error and done together: error wins
        do_reset();
        step(si(FV | FL, 32'h300));
        step(si(FV | FLD | FLE, 32'h300));
        check("lsu_err_done", sample(), mk_out(0, 0, 1, 0, 1, 32'h314));
        step(si(FV, 32'h300));
        e = mk_out(1, 1, 0, 0, 0, 0); e.mcause = 4'd5;
        check("lsu_err_mcause", sample(), e);

        // taken then not-taken branch
        do_reset();
        step(si(FV | FB | FC, 0));
        check("br_taken_c1", sample(), mk_out(1, 0, 0, 0, 0, 0));
        step(si(FV, 0));
        check("br_taken_c2", sample(), mk_out(1, 1, 0, 0, 1, 0));
        step(si(FV | FB, 0));
        check("br_not_taken", sample(), mk_out(1, 1, 0, 0, 0, 0));
        step(si(FV, 0));
        check("br_not_taken_next", sample(), mk_out(1, 1, 0, 0, 0, 0));

        // ebreak halt with decode noise, then resume
        do_reset();
        step(si(FV | FEB, 0));
        check("ebreak", sample(), '0);
        for (int k = 0; k < 10; k++) begin
            step(si(((k % 2) ? FV : 14'h0) | FE | FI | FM | FL | FJ, 32'hFFFF_FFFF));
            o = sample(); o.cnt = '0;
            e = '0; e.halted = 1'b1;
            check($sformatf("halt%0d", k), o, e);
        end
        step(si(FR, 0));
        o = sample(); o.cnt = '0;
        check("halt_resume_cycle", o, e);
        step(si(FV, 0));
        check("resume_retire", sample(), mk_out(1, 1, 0, 0, 0, 0));

        // asynchronous reset in the middle of a mul/div wait
        do_reset();
        step(si(FV | FE, 0));
        step(si(FV | FMD, 0));
        for (int k = 0; k < 6; k++) begin
            step(si(FV, 0));
            e = '0; e.cnt = 4'(k); e.mcause = 4'd11;
            check($sformatf("md_wait%0d", k), sample(), e);
        end
        rst_n = 1'b0;
        #1;
        check("md_async_reset", sample(), mk_out(1, 1, 0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;

        // randomized run against the reference model
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            s.mtvec = $urandom;
            s.f = '0;
            if ($urandom_range(0, 99) < 85) s.f |= FV;
            if ($urandom_range(0, 11) == 0) s.f |= FI;
            if ($urandom_range(0, 9) == 0)  s.f |= FE;
            if ($urandom_range(0, 15) == 0) s.f |= FEB;
            if ($urandom_range(0, 9) == 0)  s.f |= FM;
            if ($urandom_range(0, 5) == 0)  s.f |= FL;
            if ($urandom_range(0, 5) == 0)  s.f |= FMD;
            if ($urandom_range(0, 7) == 0)  s.f |= FJ;
            if ($urandom_range(0, 5) == 0)  s.f |= FB;
            if ($urandom_range(0, 1) == 0)  s.f |= FC;
            if ($urandom_range(0, 11) == 0) s.f |= FLD;
            if ($urandom_range(0, 29) == 0) s.f |= FLE;
            if ($urandom_range(0, 4) == 0)  s.f |= FMDD;
            if ($urandom_range(0, 3) == 0)  s.f |= FR;
            step(s);
            model_eval(s, e);
            check($sformatf("rand%0d", n), sample(), e);
            model_commit();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
